// File: rtl/i2s_ws_gen.sv
// Master-side I2S / DSP frame-sync generator: produces the word-select strobe,
// a frame-start pulse and a busy flag.
module i2s_ws_gen #(
    parameter int unsigned SETUP_W = 16
) (
    input  logic               sck_i,
    input  logic               rst_i,
    input  logic               cfg_en_i,
    input  logic               cfg_dsp_en_i,
    input  logic [1:0]         cfg_dsp_mode_i,
    input  logic [SETUP_W-1:0] cfg_dsp_setup_time_i,
    input  logic [4:0]         cfg_num_bits_i,
    input  logic [2:0]         cfg_num_words_i,
    output logic               ws_o,
    output logic               frame_start_o,
    output logic               busy_o
);

    localparam int unsigned BIT_W  = 5;
    localparam int unsigned WORD_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SETUP_W-1:0]  setup_cnt_q, setup_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic                ch_q, ch_d;
    logic [BIT_W-1:0]    nb_q, nb_d;
    logic [WORD_W-1:0]   nw_q, nw_d;
    logic                dsp_en_q, dsp_en_d;
    logic [1:0]          mode_q, mode_d;
    logic [SETUP_W-1:0]  setup_q, setup_d;
    logic                ws_q, ws_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;

    logic                latch_cfg;
    logic                ch_last, frame_last;
    logic [SETUP_W-1:0]  setup_lim;
    logic                nxt_ch_last, nxt_frame_last;

    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            setup_cnt_q <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            ch_q        <= 1'b0;
            nb_q        <= '0;
            nw_q        <= '0;
            dsp_en_q    <= 1'b0;
            mode_q      <= '0;
            setup_q     <= '0;
            ws_q        <= 1'b0;
            fs_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            ch_q        <= ch_d;
            nb_q        <= nb_d;
            nw_q        <= nw_d;
            dsp_en_q    <= dsp_en_d;
            mode_q      <= mode_d;
            setup_q     <= setup_d;
            ws_q        <= ws_d;
            fs_q        <= fs_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, counters and config latch
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        ch_d        = ch_q;
        latch_cfg   = 1'b0;

        ch_last    = (bit_cnt_q == nb_q) && (word_cnt_q == nw_q);
        frame_last = ch_last && (dsp_en_q || ch_q);
        setup_lim  = dsp_en_q ? setup_q : '0;

        case (state_q)
            IDLE: begin
                setup_cnt_d = '0;
                bit_cnt_d   = '0;
                word_cnt_d  = '0;
                ch_d        = 1'b0;
                if (cfg_en_i) begin
                    state_d   = SETUP;
                    latch_cfg = 1'b1;
                end
            end
            SETUP: begin
                if (setup_cnt_q == setup_lim) begin
                    state_d     = RUN;
                    setup_cnt_d = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q + SETUP_W'(1);
                end
            end
            RUN, DRAIN: begin
                if (frame_last) begin
                    latch_cfg  = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    ch_d       = 1'b0;
                    state_d    = (state_q == RUN && cfg_en_i) ? RUN : IDLE;
                end else begin
                    state_d = cfg_en_i ? RUN : DRAIN;
                    if (ch_last) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        ch_d       = 1'b1;
                    end else if (bit_cnt_q == nb_q) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        nb_d     = nb_q;
        nw_d     = nw_q;
        dsp_en_d = dsp_en_q;
        mode_d   = mode_q;
        setup_d  = setup_q;
        if (latch_cfg) begin
            nb_d     = cfg_num_bits_i;
            nw_d     = cfg_num_words_i;
            dsp_en_d = cfg_dsp_en_i;
            mode_d   = cfg_dsp_mode_i;
            setup_d  = cfg_dsp_setup_time_i;
        end
    end

    // Outputs are decoded from the next-cycle state so they register in step with it
    always_comb begin
        ws_d   = 1'b0;
        fs_d   = 1'b0;
        busy_d = 1'b0;

        nxt_ch_last    = (bit_cnt_d == nb_d) && (word_cnt_d == nw_d);
        nxt_frame_last = nxt_ch_last && (dsp_en_d || ch_d);

        case (state_d)
            SETUP: begin
                busy_d = 1'b1;
                ws_d   = dsp_en_d && (mode_d == 2'd0) && (setup_cnt_d == setup_d);
            end
            RUN, DRAIN: begin
                busy_d = 1'b1;
                fs_d   = (bit_cnt_d == '0) && (word_cnt_d == '0) && !ch_d;
                if (!dsp_en_d) begin
                    ws_d = ch_d ? !nxt_ch_last : nxt_ch_last;
                end else begin
                    case (mode_d)
                        2'd0:    ws_d = nxt_frame_last && (state_d == RUN);
                        2'd2:    ws_d = (word_cnt_d == '0);
                        default: ws_d = (bit_cnt_d == '0) && (word_cnt_d == '0);
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign ws_o          = ws_q;
    assign frame_start_o = fs_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2s_ws_gen.sv
// Directed bench for i2s_ws_gen: expected waveforms are computed from frame positions.
module tb_i2s_ws_gen;

    logic        sck_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b0;
    logic        cfg_dsp_en_i = 1'b0;
    logic [1:0]  cfg_dsp_mode_i = '0;
    logic [15:0] cfg_dsp_setup_time_i = '0;
    logic [4:0]  cfg_num_bits_i = '0;
    logic [2:0]  cfg_num_words_i = '0;
    logic        ws_o, frame_start_o, busy_o;

    int checks = 0;
    int errors = 0;

    i2s_ws_gen #(.SETUP_W(16)) dut (
        .sck_i                (sck_i),
        .rst_i                (rst_i),
        .cfg_en_i             (cfg_en_i),
        .cfg_dsp_en_i         (cfg_dsp_en_i),
        .cfg_dsp_mode_i       (cfg_dsp_mode_i),
        .cfg_dsp_setup_time_i (cfg_dsp_setup_time_i),
        .cfg_num_bits_i       (cfg_num_bits_i),
        .cfg_num_words_i      (cfg_num_words_i),
        .ws_o                 (ws_o),
        .frame_start_o        (frame_start_o),
        .busy_o               (busy_o)
    );

    always #5 sck_i = ~sck_i;

    task automatic step();
        @(posedge sck_i);
        #1;
    endtask

    // Reset, program config, enable, and advance to frame 0 cycle 0.
    task automatic start_run(input logic dsp, input logic [1:0] mode, input logic [4:0] nb,
                             input logic [2:0] nw, input logic [15:0] setup);
        rst_i = 1'b1;
        cfg_en_i = 1'b0;
        step();
        rst_i = 1'b0;
        cfg_dsp_en_i = dsp;
        cfg_dsp_mode_i = mode;
        cfg_num_bits_i = nb;
        cfg_num_words_i = nw;
        cfg_dsp_setup_time_i = setup;
        cfg_en_i = 1'b1;
        repeat ((dsp ? int'(setup) : 0) + 2) step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cfg_en_i = 1'b0;
        step();
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL reset_ws got %b exp 0", ws_o); end
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start_o); end
        start_run(1'b0, 2'd0, 5'd15, 3'd0, 16'd0);
        repeat (7) step();
        rst_i = 1'b1;
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
        checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ws got %b exp 0", ws_o); end
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL rst_mid_fs got %b exp 0", frame_start_o); end
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b exp 0", busy_o); end
        rst_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_resume_busy got %b exp 1", busy_o); end
    endtask

    task automatic test_i2s_period();
        rst_i = 1'b1;
        cfg_en_i = 1'b0;
        step();
        rst_i = 1'b0;
        cfg_dsp_en_i = 1'b0;
        cfg_dsp_mode_i = 2'd0;
        cfg_num_bits_i = 5'd15;
        cfg_num_words_i = 3'd0;
        cfg_dsp_setup_time_i = 16'd5;
        cfg_en_i = 1'b1;
        step();
        checks++; if (busy_o !== 1'b1 || frame_start_o !== 1'b0 || ws_o !== 1'b0) begin
            errors++; $display("FAIL i2s_setup got busy=%b fs=%b ws=%b exp 1 0 0", busy_o, frame_start_o, ws_o);
        end
        step();
        for (int i = 0; i < 64; i++) begin
            int c;
            logic ews, efs;
            c = i % 32;
            ews = (c >= 15 && c <= 30);
            efs = (c == 0);
            checks++; if (ws_o !== ews) begin errors++; $display("FAIL i2s_ws cyc=%0d got %b exp %b", c, ws_o, ews); end
            checks++; if (frame_start_o !== efs) begin errors++; $display("FAIL i2s_fs cyc=%0d got %b exp %b", c, frame_start_o, efs); end
            step();
        end
    endtask

    task automatic test_dsp_modes();
        for (int m = 0; m < 4; m++) begin
            start_run(1'b1, 2'(m), 5'd7, 3'd1, 16'd0);
            for (int i = 0; i < 32; i++) begin
                int c;
                logic ews;
                c = i % 16;
                case (m)
                    0: ews = (c == 15);
                    2: ews = (c <= 7);
                    default: ews = (c == 0);
                endcase
                checks++; if (ws_o !== ews) begin errors++; $display("FAIL dsp_ws mode=%0d cyc=%0d got %b exp %b", m, c, ws_o, ews); end
                checks++; if (frame_start_o !== (c == 0)) begin errors++; $display("FAIL dsp_fs mode=%0d cyc=%0d got %b exp %b", m, c, frame_start_o, c == 0); end
                step();
            end
        end
    endtask

    task automatic test_setup_delay();
        logic ews [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic efs [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rst_i = 1'b1;
        cfg_en_i = 1'b0;
        step();
        rst_i = 1'b0;
        cfg_dsp_en_i = 1'b1;
        cfg_dsp_mode_i = 2'd0;
        cfg_num_bits_i = 5'd3;
        cfg_num_words_i = 3'd0;
        cfg_dsp_setup_time_i = 16'd3;
        cfg_en_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (ws_o !== ews[k] || frame_start_o !== efs[k] || busy_o !== 1'b1) begin
                errors++; $display("FAIL setup cyc=%0d got ws=%b fs=%b busy=%b exp %b %b 1", k, ws_o, frame_start_o, busy_o, ews[k], efs[k]);
            end
        end
    endtask

    task automatic test_cfg_change();
        start_run(1'b1, 2'd1, 5'd7, 3'd0, 16'd0);
        step();
        step();
        cfg_num_bits_i = 5'd3;
        for (int i = 2; i < 20; i++) begin
            logic e;
            e = (i >= 8) && ((i - 8) % 4 == 0);
            checks++; if (frame_start_o !== e || ws_o !== e) begin
                errors++; $display("FAIL cfg_change t=%0d got fs=%b ws=%b exp %b", i, frame_start_o, ws_o, e);
            end
            step();
        end
    endtask

    task automatic test_disable();
        start_run(1'b1, 2'd0, 5'd7, 3'd0, 16'd0);
        repeat (3) step();
        cfg_en_i = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            step();
            checks++; if (busy_o !== 1'b1 || ws_o !== 1'b0 || frame_start_o !== 1'b0) begin
                errors++; $display("FAIL drain cyc=%0d got busy=%b ws=%b fs=%b exp 1 0 0", c, busy_o, ws_o, frame_start_o);
            end
        end
        step();
        checks++; if (busy_o !== 1'b0 || ws_o !== 1'b0) begin
            errors++; $display("FAIL drain_idle got busy=%b ws=%b exp 0 0", busy_o, ws_o);
        end

        start_run(1'b1, 2'd0, 5'd7, 3'd0, 16'd0);
        repeat (3) step();
        cfg_en_i = 1'b0;
        step();
        step();
        cfg_en_i = 1'b1;
        step();
        checks++; if (ws_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL rearm_c6 got ws=%b busy=%b exp 0 1", ws_o, busy_o); end
        step();
        checks++; if (ws_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL rearm_c7 got ws=%b busy=%b exp 1 1", ws_o, busy_o); end
        step();
        checks++; if (frame_start_o !== 1'b1 || ws_o !== 1'b0) begin errors++; $display("FAIL rearm_c0 got fs=%b ws=%b exp 1 0", frame_start_o, ws_o); end
    endtask

    task automatic test_boundary();
        start_run(1'b1, 2'd1, 5'd0, 3'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (ws_o !== 1'b1) begin errors++; $display("FAIL p1_mode1 t=%0d got %b exp 1", i, ws_o); end
            step();
        end
        start_run(1'b1, 2'd0, 5'd0, 3'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (ws_o !== 1'b1) begin errors++; $display("FAIL p1_mode0 t=%0d got %b exp 1", i, ws_o); end
            step();
        end
        start_run(1'b1, 2'd1, 5'd3, 3'd0, 16'd0);
        repeat (3) step();
        cfg_en_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL drop_last got busy=%b exp 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_i2s_period();
        test_dsp_modes();
        test_setup_delay();
        test_cfg_change();
        test_disable();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
